// File: rtl/tone_pkg.sv
// Shared constants and helpers for the polyphonic tone synthesiser.
// Holds the 100 MHz half-period table, octave codes and the population count.
package tone_pkg;

    localparam int          CNT_W        = 22;
    localparam logic [3:0]  NOTE_INVALID = 4'd12;

    localparam logic [1:0]  OCT_LOW  = 2'd0;
    localparam logic [1:0]  OCT_MID  = 2'd1;
    localparam logic [1:0]  OCT_HIGH = 2'd2;
    localparam logic [1:0]  OCT_TOP  = 2'd3;

    typedef struct packed {
        logic [3:0] note;
        logic [1:0] oct;
    } pitch_t;

    function automatic logic [CNT_W-1:0] half_limit(input pitch_t p, input int shift);
        logic [CNT_W-1:0] base;
        case (p.note)
            4'd0:    base = 22'd191113;
            4'd1:    base = 22'd180387;
            4'd2:    base = 22'd170262;
            4'd3:    base = 22'd160706;
            4'd4:    base = 22'd151686;
            4'd5:    base = 22'd143173;
            4'd6:    base = 22'd135137;
            4'd7:    base = 22'd127553;
            4'd8:    base = 22'd120394;
            4'd9:    base = 22'd113636;
            4'd10:   base = 22'd107258;
            4'd11:   base = 22'd101238;
            default: base = 22'd0;
        endcase
        case (p.oct)
            OCT_LOW:  base = base << 1;
            OCT_MID:  base = base;
            OCT_HIGH: base = base >> 1;
            OCT_TOP:  base = base >> 2;
            default:  base = base;
        endcase
        return base >> shift;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: pitch latch, half-period counter and tone bit.
// With VOICE_RELEASE_EN defined, a gate fall keeps the voice sounding for RELEASE_CYCLES.
module tone_voice
    import tone_pkg::*;
#(
    parameter int SIM_SHIFT      = 0,
    parameter int RELEASE_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gate,
    input  logic [3:0] note,
    input  logic [1:0] oct,
    output logic       tone,
    output logic       active
);

    pitch_t           live_s;
    pitch_t           pitch_r;
    pitch_t           pitch_sel_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_step_s;
    logic [CNT_W-1:0] limit_s;
    logic             tone_r;
    logic             tone_step_s;
    logic             active_r;
    logic             valid_s;
    logic             retrig_s;

    assign live_s   = {note, oct};
    assign valid_s  = gate && (note < NOTE_INVALID);
    assign retrig_s = active_r && (live_s != pitch_r);

`ifdef VOICE_RELEASE_EN
    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    logic [RW-1:0] rel_cnt_r;
    logic          rel_r;

    // Once the gate drops the latched pitch is frozen for the release tail.
    assign pitch_sel_s = (rel_r || !gate) ? pitch_r : live_s;
`else
    assign pitch_sel_s = live_s;
`endif

    // Next counter / tone values for a normally advancing voice.
    always_comb begin
        limit_s = half_limit(pitch_sel_s, SIM_SHIFT);
        if (cnt_r == limit_s - 22'd1) begin
            cnt_step_s  = 22'd0;
            tone_step_s = ~tone_r;
        end else begin
            cnt_step_s  = cnt_r + 22'd1;
            tone_step_s = tone_r;
        end
    end

    // Voice state: silence, retrigger, release tail or free-running count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= 22'd0;
            tone_r    <= 1'b0;
            active_r  <= 1'b0;
            pitch_r   <= '0;
`ifdef VOICE_RELEASE_EN
            rel_cnt_r <= '0;
            rel_r     <= 1'b0;
`endif
        end else begin
`ifdef VOICE_RELEASE_EN
            if (rel_r) begin
                if (gate) begin
                    rel_r     <= 1'b0;
                    rel_cnt_r <= '0;
                    cnt_r     <= 22'd0;
                    tone_r    <= 1'b0;
                    active_r  <= valid_s;
                    pitch_r   <= live_s;
                end else if (rel_cnt_r <= RW'(1)) begin
                    rel_r     <= 1'b0;
                    rel_cnt_r <= '0;
                    cnt_r     <= 22'd0;
                    tone_r    <= 1'b0;
                    active_r  <= 1'b0;
                end else begin
                    rel_cnt_r <= rel_cnt_r - RW'(1);
                    cnt_r     <= cnt_step_s;
                    tone_r    <= tone_step_s;
                end
            end else if (active_r && !gate) begin
                rel_r     <= 1'b1;
                rel_cnt_r <= RW'(RELEASE_CYCLES);
                cnt_r     <= cnt_step_s;
                tone_r    <= tone_step_s;
            end else
`endif
            if (!valid_s) begin
                cnt_r    <= 22'd0;
                tone_r   <= 1'b0;
                active_r <= 1'b0;
                pitch_r  <= live_s;
            end else if (retrig_s) begin
                cnt_r    <= 22'd0;
                tone_r   <= 1'b0;
                active_r <= 1'b1;
                pitch_r  <= live_s;
            end else begin
                cnt_r    <= cnt_step_s;
                tone_r   <= tone_step_s;
                active_r <= 1'b1;
                pitch_r  <= live_s;
            end
        end
    end

    assign tone   = tone_r;
    assign active = active_r;

endmodule

// File: rtl/poly_tone_synth.sv
// Polyphonic square-wave synthesiser mixed onto one speaker line by a first-order sigma-delta.
// Optional release tail per voice is enabled by defining VOICE_RELEASE_EN.
module poly_tone_synth
    import tone_pkg::*;
#(
    parameter int NUM_VOICES     = 4,
    parameter int SIM_SHIFT      = 0,
    parameter int RELEASE_CYCLES = 5000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_VOICES-1:0]   voice_on,
    input  logic [4*NUM_VOICES-1:0] voice_note,
    input  logic [2*NUM_VOICES-1:0] voice_oct,
    output logic                    speaker,
    output logic                    sel,
    output logic [NUM_VOICES-1:0]   voice_active
);

    localparam int AW = $clog2(3 * NUM_VOICES) + 1;

    logic [NUM_VOICES-1:0] tone_s;
    logic [NUM_VOICES-1:0] active_s;
    logic [3:0]            pop_s;
    logic [AW-1:0]         acc_r;
    logic [AW-1:0]         sum_s;
    logic                  speaker_r;
    logic                  sel_r;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        tone_voice #(
            .SIM_SHIFT      (SIM_SHIFT),
            .RELEASE_CYCLES (RELEASE_CYCLES)
        ) u_voice (
            .clk    (clk),
            .rst    (rst),
            .gate   (voice_on[i]),
            .note   (voice_note[4*i +: 4]),
            .oct    (voice_oct[2*i +: 2]),
            .tone   (tone_s[i]),
            .active (active_s[i])
        );
    end

    // Number of voices currently high plus the carried accumulator.
    always_comb begin
        pop_s = popcount8(8'(tone_s));
        sum_s = acc_r + AW'(pop_s);
    end

    // Sigma-delta: emit a one whenever the running sum covers a full voice count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r     <= '0;
            speaker_r <= 1'b0;
            sel_r     <= 1'b1;
        end else begin
            sel_r <= 1'b1;
            if (sum_s >= AW'(NUM_VOICES)) begin
                speaker_r <= 1'b1;
                acc_r     <= sum_s - AW'(NUM_VOICES);
            end else begin
                speaker_r <= 1'b0;
                acc_r     <= sum_s;
            end
        end
    end

    assign speaker      = speaker_r;
    assign sel          = sel_r;
    assign voice_active = active_s;

endmodule
